// File: rtl/cnn_stream_pkg.sv
// Shared constants and state encoding for the CNN frame streamer and the CNN top.
package cnn_stream_pkg;

    localparam int CH_COUNT       = 3;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 1024;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } stream_state_e;

endpackage

// File: rtl/chan_buffer.sv
// One channel frame buffer: simple dual-port RAM, one write port, one registered read port.
module chan_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;

    // Storage array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Read register: updates only on an issued read, so a same-cycle write is not seen.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end else begin
            rd_data_r <= rd_data_r;
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/cnn_frame_streamer.sv
// Streams a host-loaded three-channel frame into the CNN top, paced by ready.
module cnn_frame_streamer
    import cnn_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [1:0]            wr_ch,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic                  ready,
    output logic                  valid_in,
    output logic [DATA_WIDTH-1:0] data_in0,
    output logic [DATA_WIDTH-1:0] data_in1,
    output logic [DATA_WIDTH-1:0] data_in2,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    stream_state_e         state_r;
    stream_state_e         state_nxt_s;
    logic [ADDR_WIDTH-1:0] cnt_r;
    logic                  rd_issue_s;
    logic                  start_ok_s;
    logic                  wr_valid_ch_s;
    logic                  wr_drop_s;
    logic                  valid_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  wr_err_r;
    logic [DATA_WIDTH-1:0] rd_data_s [CH_COUNT];

    // Next-state and read-issue decode.
    always_comb begin
        state_nxt_s = state_r;
        rd_issue_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = STREAM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STREAM: begin
                if (ready) begin
                    rd_issue_s = 1'b1;
                    if (cnt_r == LAST_ADDR) begin
                        state_nxt_s = DRAIN;
                    end else begin
                        state_nxt_s = STREAM;
                    end
                end else begin
                    state_nxt_s = STREAM;
                end
            end
            DRAIN:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Channel 3 is not a buffer, so it neither stores nor counts as a rejected write.
    assign start_ok_s    = (state_r == IDLE) && start;
    assign wr_valid_ch_s = wr_en && (wr_ch != 2'd3);
    assign wr_drop_s     = wr_valid_ch_s && (state_r != IDLE);

    // FSM, address counter and control output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r  <= IDLE;
            cnt_r    <= {ADDR_WIDTH{1'b0}};
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            wr_err_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= rd_issue_s;
            done_r  <= (state_r == DRAIN);
            if (start_ok_s) begin
                cnt_r <= {ADDR_WIDTH{1'b0}};
            end else if (rd_issue_s) begin
                cnt_r <= cnt_r + ADDR_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (start_ok_s) begin
                busy_r <= 1'b1;
            end else if (state_r == DRAIN) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= busy_r;
            end
            if (wr_drop_s) begin
                wr_err_r <= 1'b1;
            end else begin
                wr_err_r <= wr_err_r;
            end
        end
    end

    for (genvar ch = 0; ch < CH_COUNT; ch++) begin : g_buf
        chan_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_buf (
            .clk     (clk),
            .resetn  (resetn),
            .wr_en   (wr_valid_ch_s && (state_r == IDLE) && (wr_ch == 2'(ch))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (rd_issue_s),
            .rd_addr (cnt_r),
            .rd_data (rd_data_s[ch])
        );
    end

    assign valid_in = valid_r;
    assign data_in0 = rd_data_s[0];
    assign data_in1 = rd_data_s[1];
    assign data_in2 = rd_data_s[2];
    assign busy     = busy_r;
    assign done     = done_r;
    assign wr_err   = wr_err_r;

endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Randomized bench for cnn_frame_streamer against a frame-level behavioural model.
module tb_cnn_frame_streamer;
    import cnn_stream_pkg::*;

    localparam int DW = 32;
    localparam int D  = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          resetn;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          ready;
    logic          valid_in;
    logic [DW-1:0] data_in0, data_in1, data_in2;
    logic          busy, done, wr_err;

    int checks_cnt = 0;
    int errors_cnt = 0;
    logic [DW-1:0] model_mem [CH_COUNT][D];
    bit exp_err;

    always #5 clk = ~clk;

    cnn_frame_streamer dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .ready(ready), .valid_in(valid_in),
        .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2),
        .busy(busy), .done(done), .wr_err(wr_err)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_valid"}, 64'(valid_in), 64'd0);
        check_val({tag, "_busy"}, 64'(busy), 64'd0);
        check_val({tag, "_done"}, 64'(done), 64'd0);
        check_val({tag, "_wr_err"}, 64'(wr_err), 64'd0);
        check_val({tag, "_data0"}, 64'(data_in0), 64'd0);
        check_val({tag, "_data1"}, 64'(data_in1), 64'd0);
        check_val({tag, "_data2"}, 64'(data_in2), 64'd0);
    endtask

    // Called at posedge+1; returns at the next posedge+1 with wr_en low.
    task automatic host_write(input int ch, input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_ch   = 2'(ch);
        wr_addr = AW'(addr);
        wr_data = data;
        if (ch < CH_COUNT) model_mem[ch][addr] = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
    task automatic stream_frame(input int mode, input int abort_at, input int poke_err_at,
                                input int poke_start_at, input bit same_cycle_wr);
        int  issued = 0;
        int  got    = 0;
        int  cyc    = 0;
        bit  prev_iss = 1'b0;
        bit  exp_done = 1'b0;
        bit  finished = 1'b0;
        bit  aborted  = 1'b0;
        bit  err_pend = 1'b0;
        bit  iss;
        logic [DW-1:0] v;

        start = 1'b1;
        if (same_cycle_wr) begin
            v = $urandom;
            wr_en = 1'b1; wr_ch = 2'd1; wr_addr = '0; wr_data = v;
            model_mem[1][0] = v;
        end
        @(negedge clk);
        check_val("busy_before_start", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;

        while (!finished && cyc < 6000) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: ready = 1'($urandom_range(0, 1));
            endcase
            iss = (issued < D) && ready;
            if (cyc == poke_err_at) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_addr = AW'(5); wr_data = 32'hDEAD;
                err_pend = 1'b1;
            end
            if (cyc == poke_start_at) start = 1'b1;
            @(negedge clk);
            check_val("valid", 64'(valid_in), 64'(prev_iss));
            if (prev_iss) begin
                check_val($sformatf("ch0_w%0d", got), 64'(data_in0), 64'(model_mem[0][got]));
                check_val($sformatf("ch1_w%0d", got), 64'(data_in1), 64'(model_mem[1][got]));
                check_val($sformatf("ch2_w%0d", got), 64'(data_in2), 64'(model_mem[2][got]));
                got++;
            end
            check_val("done", 64'(done), 64'(exp_done));
            check_val("busy", 64'(busy), 64'(!exp_done));
            check_val("wr_err", 64'(wr_err), 64'(exp_err));
            if (exp_done) finished = 1'b1;
            exp_done = prev_iss && (got == D);
            if (abort_at >= 0 && prev_iss && got == abort_at) begin
                resetn = 1'b0;
                exp_err = 1'b0;
                #1;
                check_zero_outputs("mid_reset");
                @(posedge clk);
                @(posedge clk);
                #1;
                check_zero_outputs("held_reset");
                resetn = 1'b1;
                wr_en = 1'b0;
                start = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            wr_en = 1'b0;
            start = 1'b0;
            if (err_pend) begin
                exp_err = 1'b1;
                err_pend = 1'b0;
            end
            prev_iss = iss;
            if (iss) issued++;
            cyc++;
        end
        ready = 1'b0;
        if (!aborted) begin
            check_val("frame_finished", 64'(finished), 64'd1);
            check_val("word_count", 64'(got), 64'(D));
            @(negedge clk);
            check_val("done_single_pulse", 64'(done), 64'd0);
            check_val("valid_after_frame", 64'(valid_in), 64'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_addr = '0; wr_data = '0;
        start = 1'b0; ready = 1'b0; exp_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        for (int i = 0; i < D; i++) begin
            host_write(0, i, DW'(i));
            host_write(1, i, DW'(i + 1000));
            host_write(2, i, DW'(i + 2000));
        end

        host_write(3, 7, 32'h0BAD);
        @(negedge clk);
        check_val("wr_err_ch3_idle", 64'(wr_err), 64'd0);
        @(posedge clk);
        #1;

        stream_frame(0, -1, -1, -1, 1'b0);
        stream_frame(1, -1, 50, 100, 1'b0);
        stream_frame(0, 300, -1, -1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            host_write($urandom_range(0, 3), $urandom_range(0, D - 1), $urandom);
        end
        stream_frame(2, -1, -1, -1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/cnn_frame_streamer.md
# cnn_frame_streamer

Synthesizable frame source that feeds the CNN top with its three input channels. It is loaded word-by-word from a host write port into three 1024-entry channel buffers. On `start` it streams one pixel per channel per accepted cycle on `data_in0/1/2` with `valid_in`, paced by the CNN's `ready`. It sits in front of the CNN top and replaces the bench-side `$readmemb`/counter stimulus in hardware builds.

## Interface
- `DATA_WIDTH`, 32: pixel word width per channel
- `DEPTH`, 1024: words per channel per frame
- `ADDR_WIDTH`, 10: `$clog2(DEPTH)`

Ports:
- `clk`  in  1  single clock, all logic on its rising edge
- `resetn`  in  1  reset is asynchronous and active-low
- `wr_en`  in  1  host write strobe
- `wr_ch`  in  2  target channel, 0..2; value 3 is ignored
- `wr_addr`  in  ADDR_WIDTH  word address
- `wr_data`  in  DATA_WIDTH  word to store
- `start`  in  1  one-cycle pulse, begins a frame
- `ready`  in  1  CNN can accept a pixel this cycle
- `valid_in`  out  1  `data_in0..2` hold a valid pixel
- `data_in0`, `data_in1`, `data_in2`  out  DATA_WIDTH each  channel 0, 1 and 2 pixels
- `busy`  out  1  high from start acceptance until `done`
- `done`  out  1  one-cycle pulse after the last pixel
- `wr_err`  out  1  sticky; set by a write attempted while busy

## Operation
- States: IDLE, STREAM, DRAIN.
- **IDLE:**
  - Writes with `wr_ch` 0..2 store `wr_data` at `wr_addr`.
  - `start` resets the address counter to 0, sets `busy`, and moves to STREAM.
- **STREAM:**
  - On each cycle with `ready`=1, issue a synchronous read of all three buffers at the counter address, then increment the counter.
  - When `ready`=0, issue no read and hold the counter.
  - Issuing address DEPTH-1 moves to DRAIN.
- **DRAIN:**
  - Lasts exactly one cycle, while the final word is presented.
  - Then `done` pulses, `busy` clears, and the state returns to IDLE.
- **Output valid:** `valid_in` equals the read-issue flag delayed one cycle. The `data_in*` registers update only when a read was issued and hold otherwise.
- **Writes while busy:** dropped, and `wr_err` is set. `wr_err` clears only on reset.
- **`start` while busy:** ignored.
- **Simultaneous `start` and `wr_en` in IDLE:** the write lands, and streaming begins next cycle. The written word is visible if its address has not yet been read.
- **Address wrap:** the counter never wraps mid-frame. The frame always ends after exactly DEPTH issued reads.
- **Reset (including mid-frame):**
  - State returns to IDLE; counter resets to 0.
  - `valid_in`, `busy`, `done` and `wr_err` reset to 0; `data_in0..2` reset to 0.
  - Buffer contents are not reset.

## Timing
- Latency: `ready` sampled high in cycle N gives `valid_in`=1 with that word in cycle N+1.
- Throughput: 1 word/cycle while `ready` is held high. A full frame with continuous `ready` takes DEPTH+1 cycles from the first read to `done`.
- `done` is asserted in the cycle after the final `valid_in`.
- `busy` rises the cycle after `start` and falls in the same cycle as `done`.
- A host write in cycle N is readable by a read issued in cycle N+1 or later. Same-cycle read and write to one address returns the old data.
- No combinational path from inputs to outputs.

## Structure
- **Shared package `cnn_stream_pkg`:**
  - state enum `{IDLE, STREAM, DRAIN}`
  - `CH_COUNT`=3
  - default `DATA_WIDTH` and `DEPTH` constants, shared with the CNN top
- **Sub-module `chan_buffer`:**
  - one simple dual-port RAM: single write port, synchronous single read port, DEPTH×DATA_WIDTH
  - instantiated three times
  - the top holds only the FSM, the counter and the output registers

## Test plan
- **Load and stream:**
  - Stimulus: write ch0[i]=i, ch1[i]=i+1000, ch2[i]=i+2000 for all 1024 words. Pulse `start`; hold `ready`=1.
  - Response: exactly 1024 `valid_in` cycles in order; word k reads (k, k+1000, k+2000); `done` pulses once, 1 cycle after the final valid.
- **Backpressure:**
  - Stimulus: toggle `ready` 1,0,0,1 repeatedly.
  - Response: no word is skipped or duplicated; `valid_in` follows `ready` delayed 1 cycle; total valid count is 1024.
- **Write while busy:**
  - Stimulus: `wr_en` to ch0 addr 5 with 0xDEAD mid-frame.
  - Response: `wr_err`=1 and stays 1; ch0[5] still reads 5 in the next frame.
- **Reset mid-frame:**
  - Stimulus: assert `resetn`=0 at word 300, release, then `start` again.
  - Response: all outputs read 0 during reset; the new frame starts at word 0 with intact buffer data.
- **Redundant and invalid controls:**
  - Stimulus: `start` pulsed during STREAM, and a write with `wr_ch`=3.
  - Response: no restart, and still exactly 1024 words; the `wr_ch`=3 write changes no buffer and does not set `wr_err`.
